load_store_unit: RTL and testbench

Initiator side of the data-memory port. Accepts one load or store request at a time from the execute stage, checks alignment and range, and drives the word-addressed memory's read/write enables. Sub-word stores are done as read-modify-write. Load data is returned byte/halfword-extracted and sign/zero-extended per RV32I funct3.

---
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_load_store_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : load_store_unit                                                  |
// | Brief   : Data-memory initiator for RV32I loads/stores with alignment and  |
// |           range checking, read-modify-write for sub-word stores.           |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module load_store_unit #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_store_data,
    output logic        resp_valid,
    output logic [31:0] resp_load_data,
    output logic        resp_error,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic [15:0] r_sdata;
    logic        r_ready;
    logic        r_mem_re;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_resp_valid;
    logic        r_resp_error;
    logic [31:0] r_resp_data;
    logic        w_illegal;

    always_comb begin
        w_illegal = 1'b0;
        case (req_funct3)
            3'b000:  w_illegal = 1'b0;
            3'b001:  w_illegal = req_address[0];
            3'b010:  w_illegal = |req_address[1:0];
            3'b100:  w_illegal = req_is_store;
            3'b101:  w_illegal = req_is_store | req_address[0];
            default: w_illegal = 1'b1;
        endcase
        if ({2'b00, req_address[31:2]} >= $unsigned(MEM_DEPTH)) begin
            w_illegal = 1'b1;
        end
    end

    function automatic logic [31:0] f_extract(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = w[{lane, 3'b000} +: 8];
        h = w[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'h0, b};
            3'b101:  res = {16'h0, h};
            default: res = w;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] w, input logic half,
                                            input logic [1:0] lane, input logic [15:0] d);
        logic [31:0] m;
        m = w;
        if (half) begin
            m[{lane[1], 4'b0000} +: 16] = d;
        end else begin
            m[{lane, 3'b000} +: 8] = d[7:0];
        end
        return m;
    endfunction

    // All outputs are registered; the async reset clears them at once, which
    // also withdraws a pending write before the next edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_is_store   <= 1'b0;
            r_funct3     <= 3'b000;
            r_lane       <= 2'b00;
            r_sdata      <= 16'h0;
            r_ready      <= 1'b1;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_data  <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_is_store <= req_is_store;
                        r_funct3   <= req_funct3;
                        r_lane     <= req_address[1:0];
                        r_sdata    <= req_store_data[15:0];
                        r_ready    <= 1'b0;
                        if (w_illegal) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                        end else begin
                            r_mem_addr <= {2'b00, req_address[31:2]};
                            if (req_is_store && (req_funct3 == 3'b010)) begin
                                r_state     <= S_WRITE;
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= req_store_data;
                            end else begin
                                r_state  <= S_READ;
                                r_mem_re <= 1'b1;
                            end
                        end
                    end
                end
                S_READ: begin
                    r_mem_re <= 1'b0;
                    if (r_is_store) begin
                        r_state     <= S_WRITE;
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= f_merge(mem_read_data, r_funct3[0], r_lane, r_sdata);
                    end else begin
                        r_state      <= S_RESP;
                        r_mem_addr   <= 32'h0;
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= f_extract(mem_read_data, r_funct3, r_lane);
                    end
                end
                S_WRITE: begin
                    r_state      <= S_RESP;
                    r_mem_we     <= 1'b0;
                    r_mem_addr   <= 32'h0;
                    r_mem_wdata  <= 32'h0;
                    r_resp_valid <= 1'b1;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_error <= 1'b0;
                    r_resp_data  <= 32'h0;
                    r_ready      <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready        = r_ready;
    assign resp_valid       = r_resp_valid;
    assign resp_load_data   = r_resp_data;
    assign resp_error       = r_resp_error;
    assign mem_read_enable  = r_mem_re;
    assign mem_write_enable = r_mem_we;
    assign mem_address      = r_mem_addr;
    assign mem_write_data   = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_load_store_unit                                               |
// | Brief   : Self-checking bench: vector table, directed multi-cycle cases,   |
// |           random traffic against an arithmetic reference model.            |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_store_data;
    logic        resp_valid;
    logic [31:0] resp_load_data;
    logic        resp_error;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    load_store_unit #(.MEM_DEPTH(1024)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_is_store     (req_is_store),
        .req_funct3       (req_funct3),
        .req_address      (req_address),
        .req_store_data   (req_store_data),
        .resp_valid       (resp_valid),
        .resp_load_data   (resp_load_data),
        .resp_error       (resp_error),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    always #5 clock = ~clock;

    logic [31:0] tb_mem  [0:1023] = '{default: 32'h0};
    logic [31:0] ref_mem [0:1023] = '{default: 32'h0};

    // Garbage when not reading so a mistimed capture shows up.
    assign mem_read_data = mem_read_enable ? tb_mem[mem_address[9:0]] : 32'hA5A5_A5A5;

    always @(posedge clock) begin
        if (mem_write_enable) tb_mem[mem_address[9:0]] <= mem_write_data;
    end

    int   total = 0;
    int   bad   = 0;
    logic en_seen = 1'b0;

    always @(negedge clock) begin
        if (!reset) begin
            total++;
            if ((mem_read_enable && mem_write_enable) ||
                (!mem_read_enable && !mem_write_enable && mem_address != 32'h0) ||
                (!mem_write_enable && mem_write_data != 32'h0) ||
                (!resp_valid && (resp_load_data != 32'h0 || resp_error)) ||
                (req_ready && (mem_read_enable || mem_write_enable || resp_valid))) begin
                bad++;
                $display("FAIL protocol t=%0t re=%0b we=%0b addr=%h wd=%h rv=%0b rd=%h err=%0b rdy=%0b (required exclusive enables, zero idle outputs)",
                         $time, mem_read_enable, mem_write_enable, mem_address, mem_write_data,
                         resp_valid, resp_load_data, resp_error, req_ready);
            end
            if (mem_read_enable || mem_write_enable) en_seen = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    // Reference model: expected outcome from the ISA rules, updating ref_mem on stores.
    task automatic model_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, output logic [31:0] ed, output logic ee,
                             output int el);
        longint idx;
        int     sh;
        int     size;
        logic [31:0] w;
        logic [31:0] mask;
        idx  = longint'(a) / 4;
        sh   = 8 * int'(a % 4);
        size = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
        ee   = (f3 == 3) || (f3 > 5) || (st && f3 >= 4) || (a % size != 0) || (idx >= 1024);
        ed   = 32'h0;
        if (ee) begin
            el = 1;
        end else if (!st) begin
            el = 2;
            w  = ref_mem[idx] >> sh;
            if (size == 4) ed = w;
            else if (size == 2) begin
                ed = w % 65536;
                if (f3 == 1 && ed >= 32768) ed = ed - 65536;
            end else begin
                ed = w % 256;
                if (f3 == 0 && ed >= 128) ed = ed - 256;
            end
        end else begin
            el   = (size == 4) ? 2 : 3;
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
            ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((d & mask) << sh);
        end
    endtask

    task automatic accept(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d);
        int g;
        @(negedge clock);
        g = 0;
        while (!req_ready && g < 10) begin
            @(negedge clock);
            g++;
        end
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_address = a; req_store_data = d;
        @(posedge clock);
        #1;
        req_valid      = 1'b0;
        req_is_store   = 1'($urandom);
        req_funct3     = 3'($urandom);
        req_address    = $urandom;
        req_store_data = $urandom;
        en_seen        = 1'b0;
    endtask

    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd, output logic re,
                           output int lat, output logic ens);
        accept(st, f3, a, d);
        rd = 32'h0; re = 1'b0; lat = 99;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (resp_valid) begin
                rd = resp_load_data; re = resp_error; lat = k;
                break;
            end
        end
        #1;
        ens = en_seen;
    endtask

    task automatic do_req(input string name, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ed, rd;
        logic ee, re, ens;
        int el, lat;
        model_req(st, f3, a, d, ed, ee, el);
        run_req(st, f3, a, d, rd, re, lat, ens);
        check({name, " data"}, rd, ed);
        check({name, " error"}, {31'h0, re}, {31'h0, ee});
        check({name, " latency"}, lat, el);
        if (ee) check({name, " no enable"}, {31'h0, ens}, 32'h0);
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] ed;
        logic        ee;
        int          el;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [31:0] rd, ed;
        logic re, ee, ens;
        int lat, el, acc, rsp, guard;
        logic [31:0] q_d[$];
        logic        q_e[$];

        tbl[0]  = '{1'b0, 3'd0, 32'h13,       32'hFFFF_FF80, 1'b0, 2};
        tbl[1]  = '{1'b0, 3'd4, 32'h13,       32'h0000_0080, 1'b0, 2};
        tbl[2]  = '{1'b0, 3'd1, 32'h12,       32'hFFFF_80FF, 1'b0, 2};
        tbl[3]  = '{1'b0, 3'd5, 32'h10,       32'h0000_7F01, 1'b0, 2};
        tbl[4]  = '{1'b0, 3'd2, 32'h10,       32'h80FF_7F01, 1'b0, 2};
        tbl[5]  = '{1'b0, 3'd0, 32'h11,       32'h0000_007F, 1'b0, 2};
        tbl[6]  = '{1'b0, 3'd2, 32'hFFC,      32'h1234_5678, 1'b0, 2};
        tbl[7]  = '{1'b0, 3'd0, 32'hFFF,      32'h0000_0012, 1'b0, 2};
        tbl[8]  = '{1'b0, 3'd2, 32'h11,       32'h0,         1'b1, 1};
        tbl[9]  = '{1'b1, 3'd1, 32'h13,       32'h0,         1'b1, 1};
        tbl[10] = '{1'b0, 3'd3, 32'h10,       32'h0,         1'b1, 1};
        tbl[11] = '{1'b1, 3'd2, 32'h1000,     32'h0,         1'b1, 1};
        tbl[12] = '{1'b1, 3'd4, 32'h10,       32'h0,         1'b1, 1};
        tbl[13] = '{1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0,        1'b1, 1};
        tbl[14] = '{1'b0, 3'd1, 32'h11,       32'h0,         1'b1, 1};
        tbl[15] = '{1'b0, 3'd6, 32'h0,        32'h0,         1'b1, 1};

        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
        req_address = 32'h0; req_store_data = 32'h0;
        #1;
        check("reset req_ready", {31'h0, req_ready}, 32'h1);
        check("reset resp_valid", {31'h0, resp_valid}, 32'h0);
        check("reset mem enables", {30'h0, mem_read_enable, mem_write_enable}, 32'h0);
        check("reset mem_address", mem_address, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // SW 0x10: write at cycle 1, response at cycle 2
        model_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, ed, ee, el);
        accept(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        @(negedge clock);
        check("sw c1 we", {31'h0, mem_write_enable}, 32'h1);
        check("sw c1 addr", mem_address, 32'h4);
        check("sw c1 wdata", mem_write_data, 32'hDEAD_BEEF);
        @(negedge clock);
        check("sw c2 resp_valid", {31'h0, resp_valid}, 32'h1);
        check("sw c2 error", {31'h0, resp_error}, 32'h0);

        do_req("init w4", 1'b1, 3'd2, 32'h10, 32'h80FF_7F01);
        do_req("init w1023", 1'b1, 3'd2, 32'hFFC, 32'h1234_5678);

        for (int i = 0; i < 16; i++) begin
            run_req(tbl[i].st, tbl[i].f3, tbl[i].a, 32'hCAFE_F00D, rd, re, lat, ens);
            check($sformatf("vec%0d data", i), rd, tbl[i].ed);
            check($sformatf("vec%0d error", i), {31'h0, re}, {31'h0, tbl[i].ee});
            check($sformatf("vec%0d latency", i), lat, tbl[i].el);
            if (tbl[i].ee) check($sformatf("vec%0d no enable", i), {31'h0, ens}, 32'h0);
        end

        // SB then SH read-modify-write on word 4
        do_req("set w4", 1'b1, 3'd2, 32'h10, 32'h1122_3344);
        model_req(1'b1, 3'd0, 32'h11, 32'h0000_00AA, ed, ee, el);
        accept(1'b1, 3'd0, 32'h11, 32'h0000_00AA);
        @(negedge clock);
        check("sb c1 re", {31'h0, mem_read_enable}, 32'h1);
        check("sb c1 addr", mem_address, 32'h4);
        @(negedge clock);
        check("sb c2 we", {31'h0, mem_write_enable}, 32'h1);
        check("sb c2 wdata", mem_write_data, 32'h1122_AA44);
        @(negedge clock);
        check("sb c3 resp_valid", {31'h0, resp_valid}, 32'h1);
        model_req(1'b1, 3'd1, 32'h12, 32'h0000_BEEF, ed, ee, el);
        accept(1'b1, 3'd1, 32'h12, 32'h0000_BEEF);
        @(negedge clock);
        @(negedge clock);
        check("sh c2 wdata", mem_write_data, 32'hBEEF_AA44);
        @(negedge clock);
        check("sh c3 resp_valid", {31'h0, resp_valid}, 32'h1);
        run_req(1'b0, 3'd2, 32'h10, 32'h0, rd, re, lat, ens);
        check("lw after rmw", rd, 32'hBEEF_AA44);

        // Reset during the WRITE cycle of an SB: nothing committed, no response
        do_req("set w5", 1'b1, 3'd2, 32'h14, 32'h5566_7788);
        accept(1'b1, 3'd0, 32'h14, 32'h0000_0011);
        @(negedge clock);
        @(negedge clock);
        check("rst sb c2 we", {31'h0, mem_write_enable}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst drops we", {31'h0, mem_write_enable}, 32'h0);
        check("rst ready", {31'h0, req_ready}, 32'h1);
        @(negedge clock);
        reset = 1'b0;
        rsp = 0;
        repeat (4) begin
            @(negedge clock);
            if (resp_valid) rsp++;
        end
        check("rst no response", rsp, 0);
        run_req(1'b0, 3'd2, 32'h14, 32'h0, rd, re, lat, ens);
        check("rst word intact", rd, 32'h5566_7788);

        // Random traffic against the model
        for (int n = 0; n < 200; n++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a;
            int          sz;
            st = 1'($urandom);
            if ($urandom_range(0, 9) < 8) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end else begin
                f3 = 3'($urandom);
            end
            case ($urandom_range(0, 19))
                0: a = 32'hFFC;
                1: a = 32'h1000 + 32'($urandom_range(0, 255));
                default: a = 32'($urandom_range(0, 63));
            endcase
            sz = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
            if ($urandom_range(0, 9) < 7) a = a - (a % sz) + ((a % 4) / sz) * 0;
            if ($urandom_range(0, 9) < 7) a = a - (a % sz);
            do_req($sformatf("rnd%0d", n), st, f3, a, $urandom);
        end

        // Back-to-back with req_valid held high
        acc = 0; rsp = 0;
        req_valid = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(negedge clock);
            if (resp_valid) begin
                rsp++;
                if (q_d.size() == 0) begin
                    check("b2b unexpected response", {31'h0, resp_valid}, 32'h0);
                end else begin
                    ed = q_d.pop_front();
                    ee = q_e.pop_front();
                    check("b2b data", resp_load_data, ed);
                    check("b2b error", {31'h0, resp_error}, {31'h0, ee});
                end
            end
            if (c >= 62) begin
                req_valid = 1'b0;
            end else if (req_ready) begin
                req_is_store   = 1'(acc % 2);
                req_funct3     = (acc % 2 == 1) ? 3'(acc % 3) : 3'((acc / 2) % 3);
                req_address    = 32'(80 + 4 * (acc % 4) + ((acc % 2 == 1 && acc % 3 == 0) ? 3 : 0));
                req_store_data = $urandom;
                model_req(req_is_store, req_funct3, req_address, req_store_data, ed, ee, el);
                q_d.push_back(ed);
                q_e.push_back(ee);
                acc++;
            end
        end
        guard = 0;
        while (q_d.size() != 0 && guard < 8) begin
            @(negedge clock);
            if (resp_valid) begin
                rsp++;
                ed = q_d.pop_front();
                ee = q_e.pop_front();
                check("b2b tail data", resp_load_data, ed);
                check("b2b tail error", {31'h0, resp_error}, {31'h0, ee});
            end
            guard++;
        end
        check("b2b response count", rsp, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
